mips_regfile_wr: RTL and testbench

- Destination side of the processor's register write-enable path: the register file consumes the qualified write strobe from the control unit and commits the data.
- Provides 32 general registers with two combinational read ports (rs, rt) and one synchronous write port.
- Register $0 reads as zero.
- Optional write-to-read bypass removes the same-cycle read-after-write hazard.
- Issues a one-cycle write acknowledge for pipeline bookkeeping.

---
 rtl/mips_pkg.sv | 15 +
 rtl/regfile_rd_port.sv | 30 +++
 rtl/mips_regfile_wr.sv | 80 ++++++++
 tb/tb_mips_regfile_wr.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and named register indices.
// Used by the register file, the decoder and the bench.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;

  localparam logic [CNT_W-1:0] CNT_MAX = 16'hFFFF;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [4:0] REG_SP   = 5'd29;
  localparam logic [4:0] REG_RA   = 5'd31;

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational register file read port:
// bypass of the in-flight write, then $0 forced to zero.
module regfile_rd_port #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] stored,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data
);

  logic hit;

  assign hit = (BYPASS != 0) && wr_en
            && (addr == wr_addr);

  always_comb begin
    data = stored;
    if (hit)
      data = wr_data;
    // $0 wins over everything, bypass included
    if (addr == '0)
      data = '0;
  end

endmodule

// File: rtl/mips_regfile_wr.sv
// 32-entry register file: 2 combinational reads,
// 1 synchronous write, write ack pulse and write counter.
module mips_regfile_wr #(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int ADDR_W = mips_pkg::ADDR_W,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd1_addr,
  output logic [DATA_W-1:0] rd1_data,
  input  logic [ADDR_W-1:0] rd2_addr,
  output logic [DATA_W-1:0] rd2_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] wr_ack_addr,
  output logic [15:0]       wr_cnt
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic              commit;

  // writes to $0 are dropped entirely
  assign commit = wr && (wr_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else if (commit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack      <= 1'b0;
      wr_ack_addr <= '0;
      wr_cnt      <= '0;
    end else begin
      wr_ack <= commit;
      if (commit) begin
        wr_ack_addr <= wr_addr;
        if (wr_cnt != mips_pkg::CNT_MAX)
          wr_cnt <= wr_cnt + 16'd1;
      end
    end
  end

  regfile_rd_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .BYPASS(BYPASS)
  ) u_rd1 (
    .addr    (rd1_addr),
    .stored  (regs[rd1_addr]),
    .wr_en   (commit),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .data    (rd1_data)
  );

  regfile_rd_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .BYPASS(BYPASS)
  ) u_rd2 (
    .addr    (rd2_addr),
    .stored  (regs[rd2_addr]),
    .wr_en   (commit),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .data    (rd2_data)
  );

endmodule

// File: tb/tb_mips_regfile_wr.sv
// Directed bench for mips_regfile_wr with an ack scoreboard
// and a register model; a BYPASS=0 copy shares the inputs.
module tb_mips_regfile_wr;
  import mips_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd1_addr;
  logic [ADDR_W-1:0] rd2_addr;

  logic [DATA_W-1:0] rd1_data, rd2_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] wr_ack_addr;
  logic [15:0]       wr_cnt;

  logic [DATA_W-1:0] rd1_data0, rd2_data0;
  logic              wr_ack0;
  logic [ADDR_W-1:0] wr_ack_addr0;
  logic [15:0]       wr_cnt0;

  mips_regfile_wr #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rd1_addr(rd1_addr), .rd1_data(rd1_data),
    .rd2_addr(rd2_addr), .rd2_data(rd2_data),
    .wr_ack(wr_ack), .wr_ack_addr(wr_ack_addr),
    .wr_cnt(wr_cnt)
  );

  mips_regfile_wr #(.BYPASS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr(wr),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rd1_addr(rd1_addr), .rd1_data(rd1_data0),
    .rd2_addr(rd2_addr), .rd2_data(rd2_data0),
    .wr_ack(wr_ack0), .wr_ack_addr(wr_ack_addr0),
    .wr_cnt(wr_cnt0)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [ADDR_W-1:0] exp_q[$];
  logic [DATA_W-1:0] mem [32];
  int                mcnt;
  logic [ADDR_W-1:0] last_ack;
  logic              p_en;
  logic [ADDR_W-1:0] p_a;
  logic [DATA_W-1:0] p_d;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mcnt = 0;
    last_ack = '0;
    p_en = 1'b0;
    exp_q.delete();
  endtask

  task automatic drive(input logic e,
                       input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] d);
    wr = e;
    wr_addr = a;
    wr_data = d;
    p_en = e && (a != REG_ZERO);
    p_a = a;
    p_d = d;
    if (p_en) exp_q.push_back(a);
  endtask

  task automatic tick(input string tag);
    logic [ADDR_W-1:0] ea;
    if (rst_n) chk({tag, "_wr_known"}, 32'($isunknown(wr)), 32'd0);
    @(negedge clk);
    if (p_en) begin
      mem[p_a] = p_d;
      if (mcnt < 65535) mcnt++;
    end
    p_en = 1'b0;
    if (exp_q.size() > 0) begin
      ea = exp_q.pop_front();
      chk({tag, "_ack"}, 32'(wr_ack), 32'd1);
      chk({tag, "_ack_addr"}, 32'(wr_ack_addr), 32'(ea));
      last_ack = ea;
    end else begin
      chk({tag, "_noack"}, 32'(wr_ack), 32'd0);
      chk({tag, "_ack_hold"}, 32'(wr_ack_addr), 32'(last_ack));
    end
    chk({tag, "_cnt"}, 32'(wr_cnt), 32'(mcnt));
    wr = 1'b0;
  endtask

  task automatic rd(input string tag,
                    input logic [ADDR_W-1:0] a1,
                    input logic [ADDR_W-1:0] a2);
    rd1_addr = a1;
    rd2_addr = a2;
    #1;
    chk({tag, "_rd1"}, rd1_data, mem[a1]);
    chk({tag, "_rd2"}, rd2_data, mem[a2]);
    chk({tag, "_nb_rd1"}, rd1_data0, mem[a1]);
  endtask

  initial begin
    rst_n = 1'b0;
    model_clear();
    drive(1'b0, '0, '0);
    rd1_addr = '0;
    rd2_addr = '0;
    #12;
    chk("por_ack", 32'(wr_ack), 32'd0);
    chk("por_cnt", 32'(wr_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic write/read
    drive(1'b1, 5'd5, 32'hDEADBEEF);
    tick("basic");
    rd("basic", 5'd5, 5'd5);

    // writes to $0 are dropped, $0 reads zero with bypass
    drive(1'b1, REG_ZERO, 32'hFFFFFFFF);
    rd1_addr = REG_ZERO;
    rd2_addr = REG_ZERO;
    #1;
    chk("zero_byp1", rd1_data, 32'd0);
    chk("zero_byp2", rd2_data, 32'd0);
    tick("zero");
    rd("zero", REG_ZERO, REG_ZERO);

    // same-cycle bypass vs stored value
    rd1_addr = 5'd7;
    rd2_addr = 5'd7;
    drive(1'b1, 5'd7, 32'h12345678);
    #1;
    chk("byp_rd1", rd1_data, 32'h12345678);
    chk("byp_rd2", rd2_data, 32'h12345678);
    chk("nobyp_rd1", rd1_data0, 32'd0);
    chk("nobyp_rd2", rd2_data0, 32'd0);
    tick("byp");
    rd("byp", 5'd7, 5'd7);

    // back-to-back writes
    drive(1'b1, 5'd1, 32'h0000_0011);
    tick("b2b1");
    drive(1'b1, 5'd2, 32'h0000_0022);
    tick("b2b2");
    drive(1'b1, 5'd3, 32'h0000_0033);
    tick("b2b3");
    rd("b2b_a", 5'd1, 5'd2);
    rd("b2b_b", 5'd3, 5'd5);
    tick("idle");

    drive(1'b1, REG_RA, 32'hA5A5_0031);
    tick("ra");
    drive(1'b1, REG_SP, 32'h7FFF_FFF0);
    tick("sp");
    rd("ra_sp", REG_RA, REG_SP);

    // async reset with registers loaded
    rd1_addr = 5'd5;
    rd2_addr = 5'd7;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_rd1", rd1_data, 32'd0);
    chk("rst_rd2", rd2_data, 32'd0);
    chk("rst_ack", 32'(wr_ack), 32'd0);
    chk("rst_cnt", 32'(wr_cnt), 32'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    rd("post_rst", 5'd1, REG_RA);

    // reset during a write cycle loses the write
    drive(1'b1, 5'd9, 32'h1111_2222);
    tick("pre9");
    rd("pre9", 5'd9, 5'd9);
    wr = 1'b1;
    wr_addr = 5'd9;
    wr_data = 32'hCAFE_F00D;
    #2;
    rst_n = 1'b0;
    wr = 1'b0;
    model_clear();
    #1;
    rst_n = 1'b1;
    tick("midrst");
    rd("midrst", 5'd9, 5'd9);

    // counter saturation
    wr = 1'b1;
    wr_addr = 5'd1;
    wr_data = 32'h5A5A_0001;
    repeat (65534) @(negedge clk);
    mcnt = 65534;
    mem[1] = 32'h5A5A_0001;
    last_ack = 5'd1;
    chk("sat_fffe", 32'(wr_cnt), 32'h0000_FFFE);
    chk("sat_ack", 32'(wr_ack), 32'd1);
    drive(1'b1, 5'd2, 32'h5A5A_0002);
    tick("sat1");
    drive(1'b1, 5'd3, 32'h5A5A_0003);
    tick("sat2");
    drive(1'b1, 5'd4, 32'h5A5A_0004);
    tick("sat3");
    chk("sat_ffff", 32'(wr_cnt), 32'h0000_FFFF);
    rd("sat_rd", 5'd1, 5'd4);
    tick("sat_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
